// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto a bank of adsr gates,
// reusing finished voices first and stealing the least recently allocated one otherwise.
module voice_allocator #(
  parameter int NUM_VOICES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_on,
  input  logic [6:0]              ev_note,
  input  logic [6:0]              ev_velocity,
  input  logic [NUM_VOICES-1:0]   voice_active,
  output logic [NUM_VOICES-1:0]   gate,
  output logic [NUM_VOICES*7-1:0] voice_note,
  output logic [NUM_VOICES*7-1:0] voice_velocity,
  output logic                    stole
);

  localparam int AW = $clog2(NUM_VOICES);

  typedef enum logic {
    READY,
    RETRIG
  } state_e;

  state_e                stateQ, stateD;
  logic [NUM_VOICES-1:0] gateQ, gateD;
  logic [6:0]            noteQ [NUM_VOICES];
  logic [6:0]            noteD [NUM_VOICES];
  logic [6:0]            velQ  [NUM_VOICES];
  logic [6:0]            velD  [NUM_VOICES];
  logic [AW-1:0]         ageQ  [NUM_VOICES];
  logic [AW-1:0]         ageD  [NUM_VOICES];
  logic [AW-1:0]         pendQ, pendD;
  logic                  stoleQ, stoleD;

  logic                  isOff;
  logic [NUM_VOICES-1:0] heldMatch;
  logic [NUM_VOICES-1:0] freeVec;
  logic                  anyMatch;
  logic                  anyFree;
  logic [AW-1:0]         matchIdx;
  logic [AW-1:0]         freeIdx;
  logic [AW-1:0]         oldestIdx;
  logic                  touch;
  logic [AW-1:0]         touchIdx;

  // Candidate voices; descending scans leave the lowest matching index selected.
  always_comb begin
    isOff     = !ev_on || (ev_velocity == 7'd0);
    heldMatch = '0;
    freeVec   = '0;
    matchIdx  = '0;
    freeIdx   = '0;
    oldestIdx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      heldMatch[i] = gateQ[i] && (noteQ[i] == ev_note);
      freeVec[i]   = !gateQ[i] && !voice_active[i];
      if (heldMatch[i]) matchIdx = AW'(i);
      if (freeVec[i]) freeIdx = AW'(i);
      if (ageQ[i] == AW'(NUM_VOICES - 1)) oldestIdx = AW'(i);
    end
    anyMatch = |heldMatch;
    anyFree  = |freeVec;
  end

  // Event handling and LRU update.
  always_comb begin
    stateD   = stateQ;
    gateD    = gateQ;
    noteD    = noteQ;
    velD     = velQ;
    pendD    = pendQ;
    stoleD   = 1'b0;
    touch    = 1'b0;
    touchIdx = '0;

    case (stateQ)
      RETRIG: begin
        gateD[pendQ] = 1'b1;
        stateD       = READY;
      end
      default: begin
        if (ev_valid) begin
          if (isOff) begin
            if (anyMatch) gateD[matchIdx] = 1'b0;
          end else if (anyMatch) begin
            velD[matchIdx]  = ev_velocity;
            gateD[matchIdx] = 1'b0;
            pendD           = matchIdx;
            touch           = 1'b1;
            touchIdx        = matchIdx;
            stateD          = RETRIG;
          end else if (anyFree) begin
            noteD[freeIdx] = ev_note;
            velD[freeIdx]  = ev_velocity;
            gateD[freeIdx] = 1'b1;
            touch          = 1'b1;
            touchIdx       = freeIdx;
          end else begin
            noteD[oldestIdx] = ev_note;
            velD[oldestIdx]  = ev_velocity;
            gateD[oldestIdx] = 1'b0;
            pendD            = oldestIdx;
            stoleD           = 1'b1;
            touch            = 1'b1;
            touchIdx         = oldestIdx;
            stateD           = RETRIG;
          end
        end
      end
    endcase

    for (int i = 0; i < NUM_VOICES; i++) begin
      ageD[i] = ageQ[i];
      if (touch && (ageQ[i] < ageQ[touchIdx])) ageD[i] = ageQ[i] + AW'(1);
    end
    if (touch) ageD[touchIdx] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= READY;
      gateQ  <= '0;
      pendQ  <= '0;
      stoleQ <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        noteQ[i] <= '0;
        velQ[i]  <= '0;
        ageQ[i]  <= AW'(i);
      end
    end else begin
      stateQ <= stateD;
      gateQ  <= gateD;
      pendQ  <= pendD;
      stoleQ <= stoleD;
      noteQ  <= noteD;
      velQ   <= velD;
      ageQ   <= ageD;
    end
  end

  always_comb begin
    ev_ready = (stateQ == READY);
    gate     = gateQ;
    stole    = stoleQ;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[i*7 +: 7]     = noteQ[i];
      voice_velocity[i*7 +: 7] = velQ[i];
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed, table-driven bench for voice_allocator with 4 voices, plus a
// hand-written reset-during-retrigger sequence.
module tb_voice_allocator;

  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ev_valid;
  logic          ev_ready;
  logic          ev_on;
  logic [6:0]    ev_note;
  logic [6:0]    ev_velocity;
  logic [NV-1:0] voice_active;
  logic [NV-1:0] gate;
  logic [NV*7-1:0] voice_note;
  logic [NV*7-1:0] voice_velocity;
  logic          stole;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          valid;
    logic          on;
    logic [6:0]    note;
    logic [6:0]    vel;
    logic [NV-1:0] active;
    logic [NV-1:0] expGate;
    logic          expReady;
    logic          expStole;
    int            cv;
    logic [6:0]    expNote;
    logic [6:0]    expVel;
  } vec_t;

  vec_t vecs[$];

  voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk            (clk),
    .reset          (reset),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_on          (ev_on),
    .ev_note        (ev_note),
    .ev_velocity    (ev_velocity),
    .voice_active   (voice_active),
    .gate           (gate),
    .voice_note     (voice_note),
    .voice_velocity (voice_velocity),
    .stole          (stole)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic valid, input logic on, input int note, input int vel,
                        input logic [NV-1:0] active, input logic [NV-1:0] expGate,
                        input logic expReady, input logic expStole, input int cv,
                        input int expNote, input int expVel);
    vec_t v;
    v.valid = valid; v.on = on; v.note = 7'(note); v.vel = 7'(vel);
    v.active = active; v.expGate = expGate; v.expReady = expReady;
    v.expStole = expStole; v.cv = cv; v.expNote = 7'(expNote); v.expVel = 7'(expVel);
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic valid, input logic on, input logic [6:0] note,
                               input logic [6:0] vel, input logic [NV-1:0] active);
    ev_valid     = valid;
    ev_on        = on;
    ev_note      = note;
    ev_velocity  = vel;
    voice_active = active;
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkVoice(input string tag, input int cv, input logic [6:0] n, input logic [6:0] v);
    checkOutput({tag, " note"}, 32'(voice_note[cv*7 +: 7]), 32'(n));
    checkOutput({tag, " vel"}, 32'(voice_velocity[cv*7 +: 7]), 32'(v));
  endtask

  initial begin
    reset = 1'b1;
    ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_velocity = '0; voice_active = '0;

    //          vld on note vel active   gate    rdy stl cv note vel
    addVec(1, 1, 60, 100, 4'b0000, 4'b0001, 1, 0, 0, 60, 100);
    addVec(1, 1, 62,  90, 4'b0001, 4'b0011, 1, 0, 1, 62,  90);
    addVec(1, 1, 64,  80, 4'b0011, 4'b0111, 1, 0, 2, 64,  80);
    addVec(1, 1, 67,  70, 4'b0111, 4'b1111, 1, 0, 3, 67,  70);
    addVec(1, 1, 69,  60, 4'b1111, 4'b1110, 0, 1, 0, 69,  60);
    addVec(1, 1, 71,  10, 4'b1111, 4'b1111, 1, 0, 0, 69,  60);
    addVec(1, 1, 62,  50, 4'b1111, 4'b1101, 0, 0, 1, 62,  50);
    addVec(0, 0,  0,   0, 4'b1111, 4'b1111, 1, 0, 1, 62,  50);
    addVec(1, 0, 64,  40, 4'b1111, 4'b1011, 1, 0, 2, 64,  80);
    addVec(1, 1, 72,  33, 4'b1111, 4'b1011, 0, 1, 2, 72,  33);
    addVec(0, 0,  0,   0, 4'b1111, 4'b1111, 1, 0, 2, 72,  33);
    addVec(1, 1, 67,   0, 4'b1111, 4'b0111, 1, 0, 3, 67,  70);
    addVec(1, 0, 71,   5, 4'b1111, 4'b0111, 1, 0, 3, 67,  70);
    addVec(1, 0, 69,   0, 4'b1111, 4'b0110, 1, 0, 0, 69,  60);
    addVec(1, 1, 74,  20, 4'b0111, 4'b1110, 1, 0, 3, 74,  20);
    addVec(1, 1, 76,  25, 4'b1110, 4'b1111, 1, 0, 0, 76,  25);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("reset gate", 32'(gate), 32'h0);
    checkOutput("reset ready", 32'(ev_ready), 32'h1);
    checkOutput("reset stole", 32'(stole), 32'h0);
    checkOutput("reset notes", 32'(voice_note), 32'h0);
    checkOutput("reset vels", 32'(voice_velocity), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].valid, vecs[i].on, vecs[i].note, vecs[i].vel, vecs[i].active);
      checkOutput($sformatf("v%0d gate", i), 32'(gate), 32'(vecs[i].expGate));
      checkOutput($sformatf("v%0d ready", i), 32'(ev_ready), 32'(vecs[i].expReady));
      checkOutput($sformatf("v%0d stole", i), 32'(stole), 32'(vecs[i].expStole));
      checkVoice($sformatf("v%0d voice%0d", i, vecs[i].cv), vecs[i].cv, vecs[i].expNote, vecs[i].expVel);
    end

    // Steal voice 1 (oldest), then reset while the retrigger is pending.
    applyStimulus(1'b1, 1'b1, 7'd78, 7'd30, 4'b1111);
    checkOutput("steal gate", 32'(gate), 32'hD);
    checkOutput("steal ready", 32'(ev_ready), 32'h0);
    checkOutput("steal stole", 32'(stole), 32'h1);
    checkVoice("steal voice1", 1, 7'd78, 7'd30);
    reset = 1'b1;
    #1;
    checkOutput("midreset gate", 32'(gate), 32'h0);
    checkOutput("midreset ready", 32'(ev_ready), 32'h1);
    checkOutput("midreset stole", 32'(stole), 32'h0);
    checkOutput("midreset notes", 32'(voice_note), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post-reset idle gate", 32'(gate), 32'h0);
    applyStimulus(1'b1, 1'b1, 7'd50, 7'd10, 4'b0000);
    checkOutput("post-reset gate", 32'(gate), 32'h1);
    checkOutput("post-reset ready", 32'(ev_ready), 32'h1);
    checkVoice("post-reset voice0", 0, 7'd50, 7'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator driving the gate inputs of a bank of `adsr` envelope generators. It accepts note-on/note-off events over a valid/ready handshake and assigns each note to a voice. Voice selection uses each envelope's `active` flag: a voice is reused only once its release has finished, or it is stolen when every voice is busy. It sits between the note-event decoder and the per-voice `adsr`/oscillator instances.

## Interface
- `NUM_VOICES`, 4, number of voices; legal range 2..16.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `ev_valid`  input  1  note event present.
- `ev_ready`  output  1  allocator can accept an event this cycle.
- `ev_on`  input  1  1 = note-on, 0 = note-off.
- `ev_note`  input  7  note number.
- `ev_velocity`  input  7  velocity. A note-on with velocity 0 is a note-off.
- `voice_active`  input  NUM_VOICES  `active` outputs of the per-voice `adsr` instances.
- `gate`  output  NUM_VOICES  gate to each `adsr`.
- `voice_note`  output  NUM_VOICES×7 (packed)  note assigned to each voice.
- `voice_velocity`  output  NUM_VOICES×7 (packed)  velocity assigned to each voice.
- `stole`  output  1  one-cycle pulse when a sounding voice is stolen.

## Operation
- Voice v is free when `gate[v]==0 && voice_active[v]==0`.
- Voice v is held when `gate[v]==1`.
- LRU ranks: each voice has a unique age in 0..NUM_VOICES-1, where 0 is the most recently allocated.
  - Allocating voice v with old age k: every voice with age < k increments, and v becomes 0.
  - Ranks always remain a permutation.
- States: READY (`ev_ready=1`) and RETRIG (`ev_ready=0`).
- Note-on is accepted in READY; the selection priority is:
  1. A held voice with `voice_note==ev_note` (retrigger): load velocity, drop gate, go to RETRIG.
  2. Otherwise the lowest-index free voice: load note and velocity, raise gate, update LRU, stay in READY.
  3. Otherwise the voice with the highest age (steal): load note and velocity, drop gate, pulse `stole`, update LRU, go to RETRIG.
- Retriggering a voice also updates LRU.
- RETRIG raises the gate of the pending voice and returns to READY.
  - The one-cycle gate low is mandatory because `adsr` detects gate edges only.
- Note-off is accepted in READY:
  - Drop the gate of the held voice whose note matches. Note and velocity stay unchanged, and LRU is untouched.
  - A note-off that matches no held voice is consumed with no effect.
- At most one held voice carries a given note; the retrigger rule guarantees this.
- Voices that are releasing (`gate=0`, `active=1`) are never chosen by rule 2. They are stealable by rule 3 like any other voice.

## Timing
- Reset values:
  - `gate=0`, `voice_note=0`, `voice_velocity=0`, `stole=0`, `ev_ready=1`.
  - State READY; age[i]=i.
- An event is accepted on a rising edge with `ev_valid && ev_ready`.
- Free-voice note-on or note-off: outputs update at the accepting edge, so there is 1 cycle of latency and 1 event/cycle throughput.
- Retrigger/steal:
  - Accepting edge: gate low, new note/velocity, `stole` high for one cycle if stealing.
  - Next edge: gate high, `ev_ready` high again. `ev_ready` is low for exactly one cycle.
- `voice_active` is sampled only at the accepting edge. It is asynchronous to events but synchronous to `clk`, with no synchronizer.
- `ev_ready` is a registered function of state and does not depend combinationally on `ev_valid`.
- Reset asserted mid-RETRIG: all gates low, READY, and the pending event is lost.

## Test plan
- After reset, note-on 60/v100 → next cycle `gate=0001`, `voice_note[0]=60`, `voice_velocity[0]=100`, `ev_ready` stays 1.
- Note-ons 60, 62, 64, 67, 69 back-to-back, all voices active, `NUM_VOICES=4` → voices 0–3 get 60/62/64/67. The fifth event steals voice 0 (oldest): `gate[0]` low one cycle, `stole` pulse, `ev_ready` low one cycle, then `gate[0]` high with note 69.
- Hold 60 on voice 0, send note-on 60/v50 → `gate[0]` 1→0→1 over two edges, velocity 50, no other voice changes, `stole=0`.
- Note-off 62 while voice 1 is held on 62 → `gate[1]=0` next cycle. Next note-on with `voice_active[1]=1` goes to another free voice; after `voice_active[1]` falls, voice 1 is eligible again.
- Note-on 64 with velocity 0 → behaves as note-off 64. Note-off 71 with no holder → no output change, event consumed in one cycle.
- Assert `reset` during RETRIG → `gate=0000`, `stole=0`, `ev_ready=1`; next note-on lands on voice 0.
